// File: rtl/keyvalue_pkg.sv
// Shared types for the key/value store: opcodes, scan FSM states and the
// match/free search result returned by keyvalue_match.
package keyvalue_pkg;

   // Index fields are sized for the largest supported table; users slice down.
   localparam int IDX_MAX_W = 16;

   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_INSERT = 2'd1,
      OP_LOOKUP = 2'd2,
      OP_DELETE = 2'd3
   } op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   typedef struct packed {
      logic                 hit;
      logic [IDX_MAX_W-1:0] hit_idx;
      logic                 free;
      logic [IDX_MAX_W-1:0] free_idx;
   } match_res_t;

endpackage

// File: rtl/keyvalue_if.sv
// Pipelined Wishbone-style request/response bundle for keyvalue_store.
interface keyvalue_if
   import keyvalue_pkg::*;
#(
   parameter int KEY_W = 16,
   parameter int VAL_W = 16,
   parameter int DEPTH = 8
);
   localparam int ADR_W = $clog2(DEPTH);

   logic             CYC_i;
   logic             STB_i;
   op_t              OP_i;
   logic [ADR_W-1:0] ADR_i;
   logic [KEY_W-1:0] KEY_i;
   logic [VAL_W-1:0] DAT_i;
   logic             STALL_o;
   logic             ACK_o;
   logic             ERR_o;
   logic [VAL_W-1:0] DAT_o;
   logic [KEY_W-1:0] KEY_o;
   logic [ADR_W-1:0] IDX_o;
   logic [ADR_W:0]   COUNT_o;
   logic             FULL_o;

   modport master (
      output CYC_i, STB_i, OP_i, ADR_i, KEY_i, DAT_i,
      input  STALL_o, ACK_o, ERR_o, DAT_o, KEY_o, IDX_o, COUNT_o, FULL_o
   );

   modport slave (
      input  CYC_i, STB_i, OP_i, ADR_i, KEY_i, DAT_i,
      output STALL_o, ACK_o, ERR_o, DAT_o, KEY_o, IDX_o, COUNT_o, FULL_o
   );
endinterface

// File: rtl/keyvalue_match.sv
// Priority search over N slots: lowest valid slot whose key equals i_key, and
// lowest invalid slot. Reported indices are offset by i_base.
module keyvalue_match
   import keyvalue_pkg::*;
#(
   parameter int KEY_W = 16,
   parameter int N     = 1,
   parameter int IDX_W = 3
)(
   input  logic [N-1:0]            i_valid,
   input  logic [N-1:0][KEY_W-1:0] i_keys,
   input  logic [KEY_W-1:0]        i_key,
   input  logic [IDX_W-1:0]        i_base,
   output match_res_t              o_res
);

   always_comb begin
      o_res = '0;
      // Walk downward so the lowest qualifying index is written last and wins.
      for (int j = N-1; j >= 0; j--) begin
         if (i_valid[j] && (i_keys[j] == i_key)) begin
            o_res.hit     = 1'b1;
            o_res.hit_idx = IDX_MAX_W'(i_base) + IDX_MAX_W'(j);
         end
         if (!i_valid[j]) begin
            o_res.free     = 1'b1;
            o_res.free_idx = IDX_MAX_W'(i_base) + IDX_MAX_W'(j);
         end
      end
   end

endmodule

// File: rtl/keyvalue_store.sv
// CAM-like key/value table on a pipelined bus slave. Default build scans one
// slot per cycle; define KEYVALUE_PARALLEL_EN for a single-cycle parallel search.
module keyvalue_store
   import keyvalue_pkg::*;
#(
   parameter  int KEY_W = 16,
   parameter  int VAL_W = 16,
   parameter  int DEPTH = 8,
   localparam int ADR_W = $clog2(DEPTH)
)(
   input  logic      sys_clk,
   input  logic      sys_rst_n,
   keyvalue_if.slave bus
);

   localparam int CNT_W = ADR_W + 1;

   logic [DEPTH-1:0]            r_valid;
   logic [DEPTH-1:0][KEY_W-1:0] r_keys;
   logic [DEPTH-1:0][VAL_W-1:0] r_vals;
   logic [CNT_W-1:0]            r_count;
   logic                        r_ack, r_err;
   logic [VAL_W-1:0]            r_dat;
   logic [KEY_W-1:0]            r_key;
   logic [ADR_W-1:0]            r_idx;

   match_res_t       w_res;
   logic             w_accept, w_go, w_last, w_rd_ok;
   op_t              w_op;
   logic [KEY_W-1:0] w_wkey;
   logic [VAL_W-1:0] w_wdat;
   logic             w_hit, w_free_any;
   logic [ADR_W-1:0] w_hit_idx, w_free_idx;
   logic             w_unused_idx;

   logic             w_ack, w_err, w_we, w_clr, w_inc, w_dec;
   logic [VAL_W-1:0] w_out_dat;
   logic [KEY_W-1:0] w_out_key;
   logic [ADR_W-1:0] w_out_idx, w_wr_idx;

   assign w_hit        = w_res.hit;
   assign w_hit_idx    = w_res.hit_idx[ADR_W-1:0];
   assign w_unused_idx = ^{w_res.hit_idx[IDX_MAX_W-1:ADR_W], w_res.free_idx[IDX_MAX_W-1:ADR_W]};
   assign w_rd_ok      = ({1'b0, bus.ADR_i} < CNT_W'(DEPTH)) && r_valid[bus.ADR_i];

`ifdef KEYVALUE_PARALLEL_EN
   keyvalue_match #(.KEY_W(KEY_W), .N(DEPTH), .IDX_W(ADR_W)) u_match (
      .i_valid (r_valid),
      .i_keys  (r_keys),
      .i_key   (bus.KEY_i),
      .i_base  ('0),
      .o_res   (w_res)
   );

   assign w_accept    = bus.CYC_i & bus.STB_i;
   assign w_go        = w_accept && (bus.OP_i != OP_READ);
   assign w_op        = bus.OP_i;
   assign w_wkey      = bus.KEY_i;
   assign w_wdat      = bus.DAT_i;
   assign w_last      = 1'b1;
   assign w_free_any  = w_res.free;
   assign w_free_idx  = w_res.free_idx[ADR_W-1:0];
   assign bus.STALL_o = 1'b0;
`else
   state_t           r_state, w_state_nx;
   logic [ADR_W-1:0] r_cnt;
   op_t              r_op;
   logic [KEY_W-1:0] r_key_l;
   logic [VAL_W-1:0] r_dat_l;
   logic             r_free_vld;
   logic [ADR_W-1:0] r_free_idx;

   keyvalue_match #(.KEY_W(KEY_W), .N(1), .IDX_W(ADR_W)) u_match (
      .i_valid (r_valid[r_cnt]),
      .i_keys  (r_keys[r_cnt]),
      .i_key   (r_key_l),
      .i_base  (r_cnt),
      .o_res   (w_res)
   );

   assign w_accept    = bus.CYC_i & bus.STB_i & (r_state == S_IDLE);
   assign w_go        = (r_state == S_SCAN) & bus.CYC_i;
   assign w_op        = r_op;
   assign w_wkey      = r_key_l;
   assign w_wdat      = r_dat_l;
   assign w_last      = (r_cnt == ADR_W'(DEPTH-1));
   // The slot under the comparator this cycle may itself be the first free one.
   assign w_free_any  = r_free_vld | w_res.free;
   assign w_free_idx  = r_free_vld ? r_free_idx : w_res.free_idx[ADR_W-1:0];
   assign bus.STALL_o = (r_state == S_SCAN);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= OP_READ;
         r_key_l    <= '0;
         r_dat_l    <= '0;
         r_free_vld <= 1'b0;
         r_free_idx <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_cnt      <= '0;
            r_op       <= bus.OP_i;
            r_key_l    <= bus.KEY_i;
            r_dat_l    <= bus.DAT_i;
            r_free_vld <= 1'b0;
         end else if (r_state == S_SCAN) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_free_vld && w_res.free) begin
               r_free_vld <= 1'b1;
               r_free_idx <= w_res.free_idx[ADR_W-1:0];
            end
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && (bus.OP_i != OP_READ)) w_state_nx = S_SCAN;
         S_SCAN:  if (!bus.CYC_i || w_ack || (r_op == OP_READ)) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end
`endif

   always_comb begin
      w_ack     = 1'b0;
      w_err     = 1'b0;
      w_out_dat = r_dat;
      w_out_key = r_key;
      w_out_idx = r_idx;
      w_we      = 1'b0;
      w_clr     = 1'b0;
      w_wr_idx  = w_hit_idx;
      w_inc     = 1'b0;
      w_dec     = 1'b0;
      if (w_accept && (bus.OP_i == OP_READ)) begin
         w_ack = 1'b1;
         if (w_rd_ok) begin
            w_out_dat = r_vals[bus.ADR_i];
            w_out_key = r_keys[bus.ADR_i];
            w_out_idx = bus.ADR_i;
         end else begin
            w_err = 1'b1;
         end
      end else if (w_go) begin
         case (w_op)
            OP_LOOKUP: begin
               if (w_hit) begin
                  w_ack     = 1'b1;
                  w_out_dat = r_vals[w_hit_idx];
                  w_out_idx = w_hit_idx;
               end else if (w_last) begin
                  w_ack = 1'b1;
                  w_err = 1'b1;
               end
            end
            OP_DELETE: begin
               if (w_hit) begin
                  w_ack     = 1'b1;
                  w_clr     = 1'b1;
                  w_dec     = 1'b1;
                  w_out_dat = r_vals[w_hit_idx];
                  w_out_idx = w_hit_idx;
               end else if (w_last) begin
                  w_ack = 1'b1;
                  w_err = 1'b1;
               end
            end
            OP_INSERT: begin
               if (w_hit) begin
                  w_ack     = 1'b1;
                  w_we      = 1'b1;
                  w_out_idx = w_hit_idx;
               end else if (w_last) begin
                  w_ack = 1'b1;
                  if (w_free_any) begin
                     w_we      = 1'b1;
                     w_inc     = 1'b1;
                     w_wr_idx  = w_free_idx;
                     w_out_idx = w_free_idx;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_valid <= '0;
         r_keys  <= '0;
         r_vals  <= '0;
         r_count <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
         r_key   <= '0;
         r_idx   <= '0;
      end else begin
         r_ack <= w_ack;
         r_err <= w_err;
         if (w_ack && !w_err) begin
            r_dat <= w_out_dat;
            r_key <= w_out_key;
            r_idx <= w_out_idx;
         end
         if (w_we) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_keys[w_wr_idx]  <= w_wkey;
            r_vals[w_wr_idx]  <= w_wdat;
         end
         if (w_clr) r_valid[w_hit_idx] <= 1'b0;
         if (w_inc)      r_count <= r_count + 1'b1;
         else if (w_dec) r_count <= r_count - 1'b1;
      end
   end

   assign bus.ACK_o   = r_ack;
   assign bus.ERR_o   = r_err;
   assign bus.DAT_o   = r_dat;
   assign bus.KEY_o   = r_key;
   assign bus.IDX_o   = r_idx;
   assign bus.COUNT_o = r_count;
   assign bus.FULL_o  = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_keyvalue_store.sv
// Self-checking bench for keyvalue_store (DEPTH=8) against an array-based
// reference model of the table and its expected completion latency.
module tb_keyvalue_store;
   import keyvalue_pkg::*;

   localparam int DEPTH = 8;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   always #5 sys_clk = ~sys_clk;

   keyvalue_if #(.KEY_W(16), .VAL_W(16), .DEPTH(DEPTH)) bus ();

   keyvalue_store #(.KEY_W(16), .VAL_W(16), .DEPTH(DEPTH)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   int checks = 0;
   int failures = 0;

   logic        m_v[DEPTH];
   logic [15:0] m_k[DEPTH];
   logic [15:0] m_d[DEPTH];
   logic [15:0] m_dat, m_key;
   logic [2:0]  m_idx;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_v[i] = 1'b0; m_k[i] = '0; m_d[i] = '0;
      end
      m_dat = '0; m_key = '0; m_idx = '0;
   endtask

   task automatic model_op(input op_t op, input logic [2:0] adr, input logic [15:0] key,
                           input logic [15:0] dat, output int lat, output logic err);
      int hit = -1;
      int fr  = -1;
      err = 1'b0;
      if (op == OP_READ) begin
         lat = 1;
         if (m_v[adr]) begin m_dat = m_d[adr]; m_key = m_k[adr]; m_idx = adr; end
         else err = 1'b1;
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (hit < 0 && m_v[i] && m_k[i] == key) hit = i;
         if (fr < 0 && !m_v[i]) fr = i;
      end
      lat = (hit >= 0) ? hit + 2 : DEPTH + 1;
      case (op)
         OP_LOOKUP: if (hit >= 0) begin m_dat = m_d[hit]; m_idx = 3'(hit); end else err = 1'b1;
         OP_DELETE: if (hit >= 0) begin
                       m_v[hit] = 1'b0; m_dat = m_d[hit]; m_idx = 3'(hit);
                    end else err = 1'b1;
         OP_INSERT: if (hit >= 0) begin
                       m_d[hit] = dat; m_idx = 3'(hit);
                    end else if (fr >= 0) begin
                       m_v[fr] = 1'b1; m_k[fr] = key; m_d[fr] = dat; m_idx = 3'(fr);
                    end else err = 1'b1;
         default: ;
      endcase
   endtask

   // Issues one request and returns at the sample point of the ACK cycle.
   task automatic drive(input op_t op, input logic [2:0] adr, input logic [15:0] key,
                        input logic [15:0] dat, output int lat);
      bus.CYC_i = 1'b1; bus.STB_i = 1'b1; bus.OP_i = op;
      bus.ADR_i = adr;  bus.KEY_i = key;  bus.DAT_i = dat;
      @(posedge sys_clk); #1;
      bus.STB_i = 1'b0;
      bus.OP_i  = op_t'($urandom_range(0, 3));
      bus.ADR_i = 3'($urandom);
      bus.KEY_i = 16'($urandom);
      bus.DAT_i = 16'($urandom);
      lat = 1;
      while (bus.ACK_o !== 1'b1 && lat < DEPTH + 8) begin
         @(posedge sys_clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      int lat; int elat; logic eerr;
      sys_rst_n = 1'b0;
      bus.CYC_i = 1'b0; bus.STB_i = 1'b0; bus.OP_i = OP_READ;
      bus.ADR_i = '0; bus.KEY_i = '0; bus.DAT_i = '0;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      model_reset();
      checks++;
      if ({bus.ACK_o, bus.ERR_o, bus.STALL_o, bus.DAT_o, bus.KEY_o, bus.IDX_o, bus.FULL_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs ack=%b err=%b stall=%b dat=%h key=%h idx=%h full=%b, all required 0",
                  bus.ACK_o, bus.ERR_o, bus.STALL_o, bus.DAT_o, bus.KEY_o, bus.IDX_o, bus.FULL_o);
      end
      checks++;
      if (bus.COUNT_o !== 4'd0) begin
         failures++; $display("FAIL reset_count got=%0d exp=0", bus.COUNT_o);
      end
      drive(OP_READ, 3'd0, 16'h0, 16'h0, lat);
      model_op(OP_READ, 3'd0, 16'h0, 16'h0, elat, eerr);
      checks++;
      if (lat !== 1 || bus.ERR_o !== 1'b1) begin
         failures++; $display("FAIL reset_read lat=%0d err=%b exp lat=1 err=1", lat, bus.ERR_o);
      end
   endtask

   task automatic test_insert_lookup();
      int lat; int elat; logic eerr;
      drive(OP_INSERT, 3'd0, 16'h0011, 16'hAAAA, lat);
      model_op(OP_INSERT, 3'd0, 16'h0011, 16'hAAAA, elat, eerr);
      checks++;
      if (lat !== 9 || bus.ERR_o !== 1'b0 || bus.IDX_o !== 3'd0 || bus.COUNT_o !== 4'd1) begin
         failures++;
         $display("FAIL insert_new lat=%0d err=%b idx=%0d cnt=%0d exp 9/0/0/1", lat, bus.ERR_o, bus.IDX_o, bus.COUNT_o);
      end
      drive(OP_LOOKUP, 3'd0, 16'h0011, 16'h0, lat);
      model_op(OP_LOOKUP, 3'd0, 16'h0011, 16'h0, elat, eerr);
      checks++;
      if (lat !== 2 || bus.DAT_o !== 16'hAAAA || bus.IDX_o !== 3'd0 || bus.ERR_o !== 1'b0) begin
         failures++;
         $display("FAIL lookup_hit lat=%0d dat=%h idx=%0d err=%b exp 2/aaaa/0/0", lat, bus.DAT_o, bus.IDX_o, bus.ERR_o);
      end
      drive(OP_INSERT, 3'd0, 16'h0011, 16'hBBBB, lat);
      model_op(OP_INSERT, 3'd0, 16'h0011, 16'hBBBB, elat, eerr);
      checks++;
      if (lat !== 2 || bus.IDX_o !== 3'd0 || bus.COUNT_o !== 4'd1 || bus.ERR_o !== 1'b0) begin
         failures++;
         $display("FAIL insert_update lat=%0d idx=%0d cnt=%0d err=%b exp 2/0/1/0", lat, bus.IDX_o, bus.COUNT_o, bus.ERR_o);
      end
      drive(OP_READ, 3'd0, 16'h0, 16'h0, lat);
      model_op(OP_READ, 3'd0, 16'h0, 16'h0, elat, eerr);
      checks++;
      if (lat !== 1 || bus.KEY_o !== 16'h0011 || bus.DAT_o !== 16'hBBBB || bus.ERR_o !== 1'b0) begin
         failures++;
         $display("FAIL read_slot0 lat=%0d key=%h dat=%h err=%b exp 1/0011/bbbb/0", lat, bus.KEY_o, bus.DAT_o, bus.ERR_o);
      end
      @(posedge sys_clk); #1;
      checks++;
      if (bus.ACK_o !== 1'b0) begin
         failures++; $display("FAIL ack_pulse got=%b exp=0", bus.ACK_o);
      end
   endtask

   task automatic test_full_reuse();
      int lat; int elat; logic eerr;
      drive(OP_DELETE, 3'd0, 16'h0011, 16'h0, lat);
      model_op(OP_DELETE, 3'd0, 16'h0011, 16'h0, elat, eerr);
      checks++;
      if (lat !== 2 || bus.DAT_o !== 16'hBBBB || bus.COUNT_o !== 4'd0 || bus.ERR_o !== 1'b0) begin
         failures++;
         $display("FAIL delete_first lat=%0d dat=%h cnt=%0d err=%b exp 2/bbbb/0/0", lat, bus.DAT_o, bus.COUNT_o, bus.ERR_o);
      end
      for (int k = 1; k <= 8; k++) begin
         drive(OP_INSERT, 3'd0, 16'(k), 16'h1000 + 16'(k), lat);
         model_op(OP_INSERT, 3'd0, 16'(k), 16'h1000 + 16'(k), elat, eerr);
         checks++;
         if (lat !== 9 || bus.IDX_o !== 3'(k - 1) || bus.COUNT_o !== 4'(k) || bus.ERR_o !== 1'b0) begin
            failures++;
            $display("FAIL fill_%0d lat=%0d idx=%0d cnt=%0d err=%b exp 9/%0d/%0d/0", k, lat, bus.IDX_o, bus.COUNT_o, bus.ERR_o, k - 1, k);
         end
      end
      checks++;
      if (bus.FULL_o !== 1'b1) begin
         failures++; $display("FAIL full_flag got=%b exp=1", bus.FULL_o);
      end
      drive(OP_INSERT, 3'd0, 16'h0009, 16'h1009, lat);
      model_op(OP_INSERT, 3'd0, 16'h0009, 16'h1009, elat, eerr);
      checks++;
      if (lat !== 9 || bus.ERR_o !== 1'b1 || bus.COUNT_o !== 4'd8 || bus.IDX_o !== 3'd7) begin
         failures++;
         $display("FAIL insert_full lat=%0d err=%b cnt=%0d idx=%0d exp 9/1/8/7", lat, bus.ERR_o, bus.COUNT_o, bus.IDX_o);
      end
      drive(OP_DELETE, 3'd0, 16'h0004, 16'h0, lat);
      model_op(OP_DELETE, 3'd0, 16'h0004, 16'h0, elat, eerr);
      checks++;
      if (lat !== 5 || bus.IDX_o !== 3'd3 || bus.COUNT_o !== 4'd7 || bus.FULL_o !== 1'b0 || bus.DAT_o !== 16'h1004) begin
         failures++;
         $display("FAIL delete_4 lat=%0d idx=%0d cnt=%0d full=%b dat=%h exp 5/3/7/0/1004",
                  lat, bus.IDX_o, bus.COUNT_o, bus.FULL_o, bus.DAT_o);
      end
      drive(OP_INSERT, 3'd0, 16'h0009, 16'h1009, lat);
      model_op(OP_INSERT, 3'd0, 16'h0009, 16'h1009, elat, eerr);
      checks++;
      if (lat !== 9 || bus.IDX_o !== 3'd3 || bus.COUNT_o !== 4'd8 || bus.ERR_o !== 1'b0) begin
         failures++;
         $display("FAIL reuse_free lat=%0d idx=%0d cnt=%0d err=%b exp 9/3/8/0", lat, bus.IDX_o, bus.COUNT_o, bus.ERR_o);
      end
   endtask

   task automatic test_abort();
      int lat; int elat; logic eerr;
      drive(OP_DELETE, 3'd0, 16'h0001, 16'h0, lat);
      model_op(OP_DELETE, 3'd0, 16'h0001, 16'h0, elat, eerr);
      for (int pass = 0; pass < 2; pass++) begin
         bus.CYC_i = 1'b1; bus.STB_i = 1'b1;
         bus.OP_i  = (pass == 0) ? OP_LOOKUP : OP_INSERT;
         bus.KEY_i = 16'h00FF; bus.DAT_i = 16'h5555;
         @(posedge sys_clk); #1 bus.STB_i = 1'b0;
         @(posedge sys_clk); #1;
         checks++;
         if (bus.STALL_o !== 1'b1 || bus.ACK_o !== 1'b0) begin
            failures++; $display("FAIL abort_scan_%0d stall=%b ack=%b exp 1/0", pass, bus.STALL_o, bus.ACK_o);
         end
         bus.CYC_i = 1'b0;
         for (int c = 0; c < DEPTH + 2; c++) begin
            @(posedge sys_clk); #1;
            checks++;
            if (bus.STALL_o !== 1'b0 || bus.ACK_o !== 1'b0) begin
               failures++; $display("FAIL abort_idle_%0d_%0d stall=%b ack=%b exp 0/0", pass, c, bus.STALL_o, bus.ACK_o);
            end
         end
         checks++;
         if (bus.COUNT_o !== 4'(m_count())) begin
            failures++; $display("FAIL abort_count_%0d got=%0d exp=%0d", pass, bus.COUNT_o, m_count());
         end
      end
      drive(OP_READ, 3'd0, 16'h0, 16'h0, lat);
      model_op(OP_READ, 3'd0, 16'h0, 16'h0, elat, eerr);
      checks++;
      if (bus.ERR_o !== 1'b1) begin
         failures++; $display("FAIL abort_no_write err=%b exp=1", bus.ERR_o);
      end
      bus.STB_i = 1'b1; bus.OP_i = OP_LOOKUP; bus.KEY_i = 16'h00FF;
      @(posedge sys_clk); #1 bus.STB_i = 1'b0;
      @(posedge sys_clk); #1 sys_rst_n = 1'b0;
      @(posedge sys_clk); #1 sys_rst_n = 1'b1; bus.CYC_i = 1'b0;
      model_reset();
      checks++;
      if (bus.COUNT_o !== 4'd0 || bus.STALL_o !== 1'b0 || bus.ACK_o !== 1'b0 || bus.FULL_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_midscan cnt=%0d stall=%b ack=%b full=%b exp 0/0/0/0", bus.COUNT_o, bus.STALL_o, bus.ACK_o, bus.FULL_o);
      end
   endtask

   task automatic test_random();
      int lat; int elat; logic eerr;
      op_t op; logic [2:0] adr; logic [15:0] key, dat;
      for (int n = 0; n < 200; n++) begin
         op  = op_t'($urandom_range(0, 3));
         adr = 3'($urandom);
         key = 16'($urandom_range(1, 11));
         dat = 16'($urandom);
         drive(op, adr, key, dat, lat);
         model_op(op, adr, key, dat, elat, eerr);
         checks++;
         if (lat !== elat || bus.ERR_o !== eerr) begin
            failures++; $display("FAIL rnd_%0d_op%0d lat=%0d err=%b exp lat=%0d err=%b", n, op, lat, bus.ERR_o, elat, eerr);
         end
         checks++;
         if (bus.DAT_o !== m_dat || bus.KEY_o !== m_key || bus.IDX_o !== m_idx) begin
            failures++;
            $display("FAIL rnd_%0d_data dat=%h key=%h idx=%0d exp %h/%h/%0d", n, bus.DAT_o, bus.KEY_o, bus.IDX_o, m_dat, m_key, m_idx);
         end
         checks++;
         if (bus.COUNT_o !== 4'(m_count()) || bus.FULL_o !== (m_count() == DEPTH)) begin
            failures++; $display("FAIL rnd_%0d_count cnt=%0d full=%b exp cnt=%0d", n, bus.COUNT_o, bus.FULL_o, m_count());
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat; int elat; logic eerr;
      drive(OP_INSERT, 3'd0, 16'h0777, 16'h7777, lat);
      model_op(OP_INSERT, 3'd0, 16'h0777, 16'h7777, elat, eerr);
      drive(OP_LOOKUP, 3'd0, 16'h0777, 16'h0, lat);
      model_op(OP_LOOKUP, 3'd0, 16'h0777, 16'h0, elat, eerr);
      checks++;
      if (bus.ERR_o !== eerr || bus.DAT_o !== m_dat || lat !== elat) begin
         failures++; $display("FAIL lookup_after_insert err=%b dat=%h lat=%0d exp %b/%h/%0d", bus.ERR_o, bus.DAT_o, lat, eerr, m_dat, elat);
      end
      bus.CYC_i = 1'b1; bus.STB_i = 1'b1; bus.OP_i = OP_READ;
      for (int i = 0; i < DEPTH; i++) begin
         bus.ADR_i = 3'(i);
         @(posedge sys_clk); #1;
         model_op(OP_READ, 3'(i), 16'h0, 16'h0, elat, eerr);
         checks++;
         if (bus.ACK_o !== 1'b1 || bus.ERR_o !== eerr || bus.DAT_o !== m_dat || bus.KEY_o !== m_key) begin
            failures++;
            $display("FAIL b2b_read_%0d ack=%b err=%b dat=%h key=%h exp 1/%b/%h/%h", i, bus.ACK_o, bus.ERR_o, bus.DAT_o, bus.KEY_o, eerr, m_dat, m_key);
         end
      end
      bus.STB_i = 1'b0;
      @(posedge sys_clk); #1;
      checks++;
      if (bus.ACK_o !== 1'b0 || bus.ERR_o !== 1'b0) begin
         failures++; $display("FAIL b2b_end ack=%b err=%b exp 0/0", bus.ACK_o, bus.ERR_o);
      end
   endtask

   initial begin
      test_reset();
      test_insert_lookup();
      test_full_reuse();
      test_abort();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
